// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus arbiter: FSM states, grant identity and the
// registered address-phase request fields.
package dbus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_BRESP,
      ST_RDATA
   } dbus_state_e;

   typedef enum logic {
      GRANT_DC = 1'b0,
      GRANT_UC = 1'b1
   } dbus_grant_e;

   localparam int DBUS_ADDR_MAX_W = 32;

   typedef struct packed {
      logic                       we;
      logic [DBUS_ADDR_MAX_W-1:0] addr;
      logic [7:0]                 len;
      logic [3:0]                 be;
   } dbus_req_t;

   localparam logic [7:0] DBUS_UC_LEN  = 8'd0;
   localparam logic [3:0] DBUS_BE_FULL = 4'hF;

endpackage

// File: rtl/dbus_rr_arb2.sv
// Two-way round-robin pick between the dcache engine and the uncached path.
// On a tie the requester that was not granted last wins.
module dbus_rr_arb2
   import dbus_pkg::*;
(
   input  logic [1:0]  req_valid,   // [0] = dcache, [1] = uncached
   input  dbus_grant_e last_grant,
   output logic        grant_any,
   output dbus_grant_e grant
);

   always_comb begin
      grant_any = |req_valid;
      grant     = GRANT_DC;
      if (req_valid == 2'b11) begin
         grant = (last_grant == GRANT_UC) ? GRANT_DC : GRANT_UC;
      end else if (req_valid[1]) begin
         grant = GRANT_UC;
      end
   end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares the external data bus between dcache line bursts and uncached single-word accesses,
// sequencing address, data and response phases and driving the data-side stall.
module dbus_arbiter
   import dbus_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          dc_req_valid,
   input  logic                          dc_req_we,
   input  logic [ADDR_WIDTH-1:0]         dc_req_addr,
   input  logic [31:0]                   dc_wdata,
   output logic                          dc_wdata_pop,
   output logic [31:0]                   dc_rdata,
   output logic                          dc_rvalid,
   output logic [$clog2(LINE_WORDS)-1:0] dc_rbeat,
   output logic                          dc_done,
   input  logic                          uc_req_valid,
   input  logic                          uc_req_we,
   input  logic [ADDR_WIDTH-1:0]         uc_req_addr,
   input  logic [3:0]                    uc_req_be,
   input  logic [31:0]                   uc_req_wdata,
   output logic [31:0]                   uc_rdata,
   output logic                          uc_done,
   output logic                          bus_req_valid,
   input  logic                          bus_req_ready,
   output logic                          bus_req_we,
   output logic [ADDR_WIDTH-1:0]         bus_req_addr,
   output logic [7:0]                    bus_req_len,
   output logic [3:0]                    bus_req_be,
   output logic [31:0]                   bus_wdata,
   output logic                          bus_wvalid,
   input  logic                          bus_wready,
   output logic                          bus_wlast,
   input  logic [31:0]                   bus_rdata,
   input  logic                          bus_rvalid,
   input  logic                          bus_rlast,
   input  logic                          bus_bvalid,
   output logic                          dbus_ready
);

   localparam int         BEAT_W = $clog2(LINE_WORDS);
   localparam logic [7:0] DC_LEN = 8'(LINE_WORDS - 1);

   dbus_state_e state_reg, state_next;
   dbus_grant_e grant_reg, grant_next;
   dbus_grant_e last_grant_reg, last_grant_next;
   dbus_req_t   req_reg, req_next;
   logic [7:0]  cnt_reg, cnt_next;

   logic        arb_any;
   dbus_grant_e arb_grant;
   logic        is_dc;

   dbus_rr_arb2 u_rr_arb2 (
      .req_valid  ({uc_req_valid, dc_req_valid}),
      .last_grant (last_grant_reg),
      .grant_any  (arb_any),
      .grant      (arb_grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         grant_reg      <= GRANT_DC;
         last_grant_reg <= GRANT_UC;
         req_reg        <= '0;
         cnt_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         req_reg        <= req_next;
         cnt_reg        <= cnt_next;
      end
   end

   // Address-phase fields come straight from the request captured at grant time.
   assign bus_req_we   = req_reg.we;
   assign bus_req_addr = req_reg.addr[ADDR_WIDTH-1:0];
   assign bus_req_len  = req_reg.len;
   assign bus_req_be   = req_reg.be;
   assign is_dc        = (grant_reg == GRANT_DC);

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      req_next        = req_reg;
      cnt_next        = cnt_reg;
      bus_req_valid   = 1'b0;
      bus_wvalid      = 1'b0;
      bus_wdata       = '0;
      bus_wlast       = 1'b0;
      dc_wdata_pop    = 1'b0;
      dc_rdata        = '0;
      dc_rvalid       = 1'b0;
      dc_rbeat        = '0;
      dc_done         = 1'b0;
      uc_rdata        = '0;
      uc_done         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (arb_any) begin
               grant_next      = arb_grant;
               last_grant_next = arb_grant;
               cnt_next        = '0;
               state_next      = ST_ADDR;
               if (arb_grant == GRANT_DC) begin
                  req_next.we   = dc_req_we;
                  req_next.addr = DBUS_ADDR_MAX_W'(dc_req_addr);
                  req_next.len  = DC_LEN;
                  req_next.be   = DBUS_BE_FULL;
               end else begin
                  req_next.we   = uc_req_we;
                  req_next.addr = DBUS_ADDR_MAX_W'(uc_req_addr);
                  req_next.len  = DBUS_UC_LEN;
                  req_next.be   = uc_req_be;
               end
            end
         end
         ST_ADDR: begin
            bus_req_valid = 1'b1;
            if (bus_req_ready) begin
               state_next = req_reg.we ? ST_WDATA : ST_RDATA;
            end
         end
         ST_WDATA: begin
            bus_wvalid = 1'b1;
            bus_wdata  = is_dc ? dc_wdata : uc_req_wdata;
            bus_wlast  = (cnt_reg == req_reg.len);
            if (bus_wready) begin
               cnt_next     = cnt_reg + 8'd1;
               dc_wdata_pop = is_dc;
               if (bus_wlast) begin
                  state_next = ST_BRESP;
               end
            end
         end
         ST_BRESP: begin
            if (bus_bvalid) begin
               dc_done    = is_dc;
               uc_done    = ~is_dc;
               state_next = ST_IDLE;
            end
         end
         ST_RDATA: begin
            if (is_dc) begin
               dc_rvalid = bus_rvalid;
               dc_rdata  = bus_rdata;
               dc_rbeat  = cnt_reg[BEAT_W-1:0];
            end else begin
               uc_rdata = bus_rdata;
            end
            if (bus_rvalid) begin
               cnt_next = cnt_reg + 8'd1;
               // The slave's rlast ends the burst; the counter only labels beats.
               if (bus_rlast) begin
                  dc_done    = is_dc;
                  uc_done    = ~is_dc;
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      dbus_ready = ~(dc_req_valid | uc_req_valid) | dc_done | uc_done;
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter: the bench plays both requesters and the bus slave and
// predicts every output from a transaction-level model of the bus protocol.
module tb_dbus_arbiter;

   localparam int LW = 8;

   logic        clk;
   logic        rst;
   logic        dc_req_valid;
   logic        dc_req_we;
   logic [31:0] dc_req_addr;
   logic [31:0] dc_wdata;
   logic        dc_wdata_pop;
   logic [31:0] dc_rdata;
   logic        dc_rvalid;
   logic [2:0]  dc_rbeat;
   logic        dc_done;
   logic        uc_req_valid;
   logic        uc_req_we;
   logic [31:0] uc_req_addr;
   logic [3:0]  uc_req_be;
   logic [31:0] uc_req_wdata;
   logic [31:0] uc_rdata;
   logic        uc_done;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_req_we;
   logic [31:0] bus_req_addr;
   logic [7:0]  bus_req_len;
   logic [3:0]  bus_req_be;
   logic [31:0] bus_wdata;
   logic        bus_wvalid;
   logic        bus_wready;
   logic        bus_wlast;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;
   logic        bus_rlast;
   logic        bus_bvalid;
   logic        dbus_ready;

   dbus_arbiter #(.LINE_WORDS(LW), .ADDR_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .dc_req_valid  (dc_req_valid),
      .dc_req_we     (dc_req_we),
      .dc_req_addr   (dc_req_addr),
      .dc_wdata      (dc_wdata),
      .dc_wdata_pop  (dc_wdata_pop),
      .dc_rdata      (dc_rdata),
      .dc_rvalid     (dc_rvalid),
      .dc_rbeat      (dc_rbeat),
      .dc_done       (dc_done),
      .uc_req_valid  (uc_req_valid),
      .uc_req_we     (uc_req_we),
      .uc_req_addr   (uc_req_addr),
      .uc_req_be     (uc_req_be),
      .uc_req_wdata  (uc_req_wdata),
      .uc_rdata      (uc_rdata),
      .uc_done       (uc_done),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_req_we    (bus_req_we),
      .bus_req_addr  (bus_req_addr),
      .bus_req_len   (bus_req_len),
      .bus_req_be    (bus_req_be),
      .bus_wdata     (bus_wdata),
      .bus_wvalid    (bus_wvalid),
      .bus_wready    (bus_wready),
      .bus_wlast     (bus_wlast),
      .bus_rdata     (bus_rdata),
      .bus_rvalid    (bus_rvalid),
      .bus_rlast     (bus_rlast),
      .bus_bvalid    (bus_bvalid),
      .dbus_ready    (dbus_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: which bus phase the current transaction is in, who owns it, and its fields.
   typedef enum {M_IDLE, M_ADDR, M_WR, M_RESP, M_RD} mph_e;
   mph_e        ph = M_IDLE;
   bit          m_gnt_uc;
   bit          m_last_uc = 1'b1;
   int          m_beat;
   bit          cur_we;
   logic [31:0] cur_addr;
   int          cur_len;
   logic [3:0]  cur_be;
   bit          dc_done_m, uc_done_m;

   bit          dc_go, uc_go, auto_req;
   logic [31:0] dc_line [LW];
   int          dc_ptr;
   int          pr_ready = 100, pr_wready = 100, pr_rvalid = 100, pr_bvalid = 100, pr_raise = 30;
   bit          fix_rdata;
   logic [31:0] rdata_val;

   int          cyc, n_dc_rvalid, n_pop, n_wlast, n_wvalid, n_dc_done, n_uc_done, uc_done_cyc;
   logic [31:0] last_uc_rdata;
   bit          gnt_log [$];

   function automatic bit coin(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic new_dc(input bit we, input logic [31:0] addr);
      dc_req_we   = we;
      dc_req_addr = addr & 32'hFFFF_FFE0;
      for (int i = 0; i < LW; i++) dc_line[i] = $urandom;
      dc_go = 1'b1;
   endtask

   task automatic new_uc(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
      uc_req_we    = we;
      uc_req_addr  = addr & 32'hFFFF_FFFC;
      uc_req_be    = be;
      uc_req_wdata = wdata;
      uc_go        = 1'b1;
   endtask

   task automatic drive_slave_idle();
      bus_req_ready = 1'b0;
      bus_wready    = 1'b0;
      bus_rvalid    = 1'b0;
      bus_rlast     = 1'b0;
      bus_bvalid    = 1'b0;
      bus_rdata     = '0;
   endtask

   task automatic step();
      bit e_addr, e_w, e_rb, e_done, e_dc_done, e_uc_done;
      @(posedge clk);
      #1;
      cyc++;
      // Requesters: drop the cycle after done, otherwise maybe raise a new request.
      if (dc_done_m) dc_req_valid = 1'b0;
      else if (!dc_req_valid) begin
         if (!dc_go && auto_req && coin(pr_raise)) new_dc(1'($urandom_range(1)), $urandom);
         if (dc_go) begin
            dc_req_valid = 1'b1;
            dc_go        = 1'b0;
            dc_ptr       = 0;
         end
      end
      if (uc_done_m) uc_req_valid = 1'b0;
      else if (!uc_req_valid) begin
         if (!uc_go && auto_req && coin(pr_raise))
            new_uc(1'($urandom_range(1)), $urandom, 4'($urandom_range(1, 15)), $urandom);
         if (uc_go) begin
            uc_req_valid = 1'b1;
            uc_go        = 1'b0;
         end
      end
      dc_wdata = dc_line[dc_ptr % LW];
      // Slave responses follow the protocol phase the model believes is active.
      bus_req_ready = (ph == M_ADDR) && coin(pr_ready);
      bus_wready    = (ph == M_WR) && coin(pr_wready);
      bus_bvalid    = (ph == M_RESP) && coin(pr_bvalid);
      bus_rvalid    = (ph == M_RD) && coin(pr_rvalid);
      bus_rlast     = bus_rvalid && (m_beat == cur_len);
      bus_rdata     = fix_rdata ? rdata_val : $urandom;

      e_addr    = (ph == M_ADDR);
      e_w       = (ph == M_WR);
      e_rb      = (ph == M_RD) && bus_rvalid;
      e_done    = ((ph == M_RESP) && bus_bvalid) || (e_rb && bus_rlast);
      e_dc_done = e_done && !m_gnt_uc;
      e_uc_done = e_done && m_gnt_uc;

      @(negedge clk);
      chk("bus_req_valid", 32'(bus_req_valid), 32'(e_addr));
      if (e_addr) begin
         chk("bus_req_addr", bus_req_addr, cur_addr);
         chk("bus_req_we", 32'(bus_req_we), 32'(cur_we));
         chk("bus_req_len", 32'(bus_req_len), 32'(cur_len));
         chk("bus_req_be", 32'(bus_req_be), 32'(cur_be));
      end
      chk("bus_wvalid", 32'(bus_wvalid), 32'(e_w));
      if (e_w) begin
         chk("bus_wdata", bus_wdata, m_gnt_uc ? uc_req_wdata : dc_line[dc_ptr % LW]);
         chk("bus_wlast", 32'(bus_wlast), 32'(m_beat == cur_len));
      end
      chk("dc_wdata_pop", 32'(dc_wdata_pop), 32'(e_w && bus_wready && !m_gnt_uc));
      chk("dc_rvalid", 32'(dc_rvalid), 32'(e_rb && !m_gnt_uc));
      if (e_rb && !m_gnt_uc) begin
         chk("dc_rbeat", 32'(dc_rbeat), 32'(m_beat));
         chk("dc_rdata", dc_rdata, bus_rdata);
      end
      chk("dc_done", 32'(dc_done), 32'(e_dc_done));
      chk("uc_done", 32'(uc_done), 32'(e_uc_done));
      if (e_uc_done && !cur_we) chk("uc_rdata", uc_rdata, bus_rdata);
      chk("dbus_ready", 32'(dbus_ready), 32'(!(dc_req_valid || uc_req_valid) || e_done));

      if (dc_rvalid) n_dc_rvalid++;
      if (dc_wdata_pop) n_pop++;
      if (bus_wvalid) n_wvalid++;
      if (bus_wvalid && bus_wready && bus_wlast) n_wlast++;
      if (dc_done) begin
         n_dc_done++;
         gnt_log.push_back(1'b0);
      end
      if (uc_done) begin
         n_uc_done++;
         gnt_log.push_back(1'b1);
         uc_done_cyc   = cyc;
         last_uc_rdata = uc_rdata;
      end
      if (e_done)
         $display("[cyc %0d] %s %s addr=0x%08h len=%0d", cyc, m_gnt_uc ? "UC" : "DC",
                  cur_we ? "write" : "read", cur_addr, cur_len);

      // Advance the model.
      dc_done_m = e_dc_done;
      uc_done_m = e_uc_done;
      if (e_w && bus_wready && !m_gnt_uc) dc_ptr++;
      case (ph)
         M_IDLE: if (dc_req_valid || uc_req_valid) begin
            m_gnt_uc  = (dc_req_valid && uc_req_valid) ? !m_last_uc : uc_req_valid;
            m_last_uc = m_gnt_uc;
            cur_we    = m_gnt_uc ? uc_req_we : dc_req_we;
            cur_addr  = m_gnt_uc ? uc_req_addr : dc_req_addr;
            cur_len   = m_gnt_uc ? 0 : LW - 1;
            cur_be    = m_gnt_uc ? uc_req_be : 4'hF;
            m_beat    = 0;
            ph        = M_ADDR;
         end
         M_ADDR: if (bus_req_ready) ph = cur_we ? M_WR : M_RD;
         M_WR: if (bus_wready) begin
            if (m_beat == cur_len) ph = M_RESP;
            m_beat++;
         end
         M_RESP: if (bus_bvalid) ph = M_IDLE;
         M_RD: if (bus_rvalid) begin
            if (bus_rlast) ph = M_IDLE;
            m_beat++;
         end
         default: ph = M_IDLE;
      endcase
   endtask

   task automatic check_zero();
      chk("rst_bus_req_valid", 32'(bus_req_valid), 0);
      chk("rst_bus_req_we", 32'(bus_req_we), 0);
      chk("rst_bus_req_addr", bus_req_addr, 0);
      chk("rst_bus_req_len", 32'(bus_req_len), 0);
      chk("rst_bus_req_be", 32'(bus_req_be), 0);
      chk("rst_bus_wvalid", 32'(bus_wvalid), 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_bus_wlast", 32'(bus_wlast), 0);
      chk("rst_dc_wdata_pop", 32'(dc_wdata_pop), 0);
      chk("rst_dc_rvalid", 32'(dc_rvalid), 0);
      chk("rst_dc_rdata", dc_rdata, 0);
      chk("rst_dc_rbeat", 32'(dc_rbeat), 0);
      chk("rst_dc_done", 32'(dc_done), 0);
      chk("rst_uc_rdata", uc_rdata, 0);
      chk("rst_uc_done", 32'(uc_done), 0);
      chk("rst_dbus_ready", 32'(dbus_ready), 1);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst          = 1'b1;
      dc_req_valid = 1'b0;
      uc_req_valid = 1'b0;
      dc_go        = 1'b0;
      uc_go        = 1'b0;
      drive_slave_idle();
      repeat (n) @(posedge clk);
      #1;
      rst       = 1'b0;
      ph        = M_IDLE;
      m_last_uc = 1'b1;
      m_beat    = 0;
      dc_done_m = 1'b0;
      uc_done_m = 1'b0;
      @(negedge clk);
      check_zero();
   endtask

   task automatic wait_count(input string tag, input int target, input bit use_uc, input int budget);
      int k;
      k = 0;
      while (((use_uc ? n_uc_done : n_dc_done) < target) && k < budget) begin
         step();
         k++;
      end
      chk(tag, 32'((use_uc ? n_uc_done : n_dc_done) >= target), 1);
   endtask

   initial begin
      int start, base;
      bit done_ok;
      rst          = 1'b1;
      dc_req_valid = 1'b0;
      dc_req_we    = 1'b0;
      dc_req_addr  = '0;
      dc_wdata     = '0;
      uc_req_valid = 1'b0;
      uc_req_we    = 1'b0;
      uc_req_addr  = '0;
      uc_req_be    = '0;
      uc_req_wdata = '0;
      drive_slave_idle();
      for (int i = 0; i < LW; i++) dc_line[i] = '0;
      do_reset(3);

      // Minimum-latency uncached load.
      fix_rdata = 1'b1;
      rdata_val = 32'h1234_5678;
      new_uc(1'b0, 32'hBFC0_0010, 4'hF, 32'h0);
      start       = cyc + 1;
      uc_done_cyc = -1;
      base        = n_uc_done;
      wait_count("uc_load_timeout", base + 1, 1'b1, 20);
      chk("uc_load_latency", 32'(uc_done_cyc - start + 1), 3);
      chk("uc_load_rdata", last_uc_rdata, 32'h1234_5678);
      fix_rdata = 1'b0;

      // Line refill with a gappy read stream.
      pr_rvalid   = 50;
      n_dc_rvalid = 0;
      new_dc(1'b0, 32'h8000_0040);
      wait_count("dc_refill_timeout", n_dc_done + 1, 1'b0, 200);
      chk("dc_refill_beats", 32'(n_dc_rvalid), LW);

      // Victim writeback with a stalling write channel.
      pr_wready = 50;
      pr_bvalid = 50;
      n_pop     = 0;
      n_wlast   = 0;
      new_dc(1'b1, 32'h8000_0080);
      wait_count("dc_wb_timeout", n_dc_done + 1, 1'b0, 300);
      chk("dc_wb_pops", 32'(n_pop), LW);
      chk("dc_wb_wlast", 32'(n_wlast), 1);

      // Ties after reset alternate starting with the dcache.
      do_reset(2);
      gnt_log.delete();
      for (int r = 0; r < 3; r++) begin
         new_dc(1'($urandom_range(1)), $urandom);
         new_uc(1'($urandom_range(1)), $urandom, 4'($urandom_range(1, 15)), $urandom);
         wait_count("tie_timeout", n_uc_done + 1, 1'b1, 300);
         step();
      end
      chk("tie_grant_count", 32'(gnt_log.size()), 6);
      for (int i = 0; i < gnt_log.size() && i < 6; i++)
         chk("tie_grant_order", 32'(gnt_log[i]), 32'(i % 2));

      // Address phase stalled by the slave.
      pr_ready = 0;
      n_wvalid = 0;
      new_uc(1'b1, 32'h1000_0004, 4'h3, 32'hCAFE_F00D);
      repeat (6) step();
      chk("addr_stall_no_data", 32'(n_wvalid), 0);
      pr_ready = 100;
      wait_count("addr_stall_timeout", n_uc_done + 1, 1'b1, 50);

      // Reset in the middle of a refill, then an ordinary uncached access.
      pr_rvalid   = 100;
      n_dc_rvalid = 0;
      new_dc(1'b0, 32'h8000_0100);
      for (int k = 0; k < 50 && n_dc_rvalid < 3; k++) step();
      chk("midrst_beats_before", 32'(n_dc_rvalid), 3);
      do_reset(1);
      new_uc(1'b0, 32'h2000_0000, 4'hF, 32'h0);
      wait_count("post_rst_uc_timeout", n_uc_done + 1, 1'b1, 20);

      // Free-running random traffic.
      do_reset(2);
      base     = n_dc_done + n_uc_done;
      auto_req = 1'b1;
      for (int chunk = 0; chunk < 10; chunk++) begin
         pr_ready  = $urandom_range(20, 100);
         pr_wready = $urandom_range(20, 100);
         pr_rvalid = $urandom_range(20, 100);
         pr_bvalid = $urandom_range(20, 100);
         pr_raise  = $urandom_range(5, 60);
         repeat (200) step();
      end
      auto_req = 1'b0;
      done_ok  = 1'b0;
      for (int k = 0; k < 1000 && !done_ok; k++) begin
         step();
         done_ok = (ph == M_IDLE) && !dc_req_valid && !uc_req_valid && !dc_go && !uc_go;
      end
      chk("random_drain", 32'(done_ok), 1);
      chk("random_traffic", 32'((n_dc_done + n_uc_done - base) > 20), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
